// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes and the responder FSM state encoding.
package mem_pkg;

   localparam int unsigned DATA_W = 32;

   // RV32I load/store funct3 codes (stores use the first three)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for the data-memory responder.
//   write_i     : 1=store, 0=load
//   funct3_i    : RV32I load/store funct3
//   offset_i    : byte offset within the word (addr[1:0])
//   wdata_i     : store data, value in the low bits
//   rword_i     : current contents of the addressed word
//   byte_en_o   : store byte enables (little-endian lanes)
//   wdata_o     : store data replicated onto the selected lanes
//   load_o      : extended load result
//   align_err_o : misaligned access or illegal funct3
module dmem_align
   import mem_pkg::*;
(
   input  logic              write_i,
   input  logic [2:0]        funct3_i,
   input  logic [1:0]        offset_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rword_i,
   output logic [3:0]        byte_en_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] load_o,
   output logic              align_err_o
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        misalign;
   logic        illegal;

   always_comb begin
      byte_en_o = 4'b0000;
      wdata_o   = '0;
      load_o    = '0;
      misalign  = 1'b0;
      lane_b    = rword_i[{offset_i, 3'b000} +: 8];
      lane_h    = rword_i[{offset_i[1], 4'b0000} +: 16];

      // Access size lives in funct3[1:0] for both loads and stores
      unique case (funct3_i[1:0])
         2'b00: begin
            byte_en_o = 4'b0001 << offset_i;
            wdata_o   = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            misalign  = offset_i[0];
            byte_en_o = 4'b0011 << offset_i;
            wdata_o   = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            misalign  = |offset_i;
            byte_en_o = 4'b1111;
            wdata_o   = wdata_i;
         end
         default: ;
      endcase

      // Loads reject 011/110/111; stores reject everything above SW
      illegal = write_i ? (funct3_i > F3_W)
                        : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));

      unique case (funct3_i)
         F3_B:    load_o = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_o = {24'h0, lane_b};
         F3_H:    load_o = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_o = {16'h0, lane_h};
         F3_W:    load_o = rword_i;
         default: load_o = '0;
      endcase

      align_err_o = misalign | illegal;
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory port. Accepts one request at
// a time, waits LATENCY cycles, then issues a one-cycle response.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata : request fields, latched on accept
//   rsp_valid                 : one-cycle response pulse
//   rsp_rdata, rsp_err        : load data / error flag, zero outside rsp_valid
module dmem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam bit          ZERO_LAT = (LATENCY == 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_ready_q, rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0]  rsp_rdata_q;

   logic               write_q;
   logic [2:0]         funct3_q;
   logic [31:0]        addr_q;
   logic [DATA_W-1:0]  wdata_q;

   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic               accept;
   logic               sel_live;
   logic               cur_write;
   logic [2:0]         cur_funct3;
   logic [31:0]        cur_addr;
   logic [DATA_W-1:0]  cur_wdata;
   logic [ADDR_W-1:0]  waddr;
   logic [DATA_W-1:0]  rd_word;
   logic [3:0]         byte_en;
   logic [DATA_W-1:0]  wdata_sh;
   logic [DATA_W-1:0]  load_data;
   logic               align_err;
   logic               out_of_range;
   logic               err;
   logic               enter_resp;
   logic               mem_we;

   assign accept = req_valid & req_ready_q;

   // With zero latency RESP is entered on the accept edge itself, before the
   // latches hold the request, so IDLE works from the live request fields.
   assign sel_live   = (state_q == ST_IDLE);
   assign cur_write  = sel_live ? req_write  : write_q;
   assign cur_funct3 = sel_live ? req_funct3 : funct3_q;
   assign cur_addr   = sel_live ? req_addr   : addr_q;
   assign cur_wdata  = sel_live ? req_wdata  : wdata_q;

   assign waddr        = cur_addr[ADDR_W+1:2];
   assign out_of_range = |cur_addr[31:ADDR_W+2];
   assign rd_word      = mem_q[waddr];
   assign err          = align_err | out_of_range;

   dmem_align u_align (
      .write_i     (cur_write),
      .funct3_i    (cur_funct3),
      .offset_i    (cur_addr[1:0]),
      .wdata_i     (cur_wdata),
      .rword_i     (rd_word),
      .byte_en_o   (byte_en),
      .wdata_o     (wdata_sh),
      .load_o      (load_data),
      .align_err_o (align_err)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ZERO_LAT ? ST_RESP : ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
   // rst gates the write so a store racing an asserted reset is dropped
   assign mem_we     = enter_resp & cur_write & ~err & ~rst;

   // FSM, counter, request latches and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         write_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= (state_d == ST_IDLE);
         rsp_valid_q <= enter_resp;
         rsp_err_q   <= enter_resp & err;
         rsp_rdata_q <= (enter_resp & ~cur_write & ~err) ? load_data : '0;
         if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
      end
   end

   // Storage array, not reset; per-lane merge keeps unselected bytes
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_q[waddr][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses LATENCY=2, instance b
// uses LATENCY=0. Expected responses are queued at accept and checked by a
// per-instance monitor when rsp_valid appears.
module tb_dmem_responder;
   import mem_pkg::*;

   localparam int unsigned LAT_A = 2;
   localparam int unsigned LAT_B = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        a_valid = 1'b0, a_write = 1'b0, a_ready, a_rsp_valid, a_rsp_err;
   logic [2:0]  a_funct3 = 3'b000;
   logic [31:0] a_addr = '0, a_wdata = '0, a_rsp_rdata;

   logic        b_valid = 1'b0, b_write = 1'b0, b_ready, b_rsp_valid, b_rsp_err;
   logic [2:0]  b_funct3 = 3'b000;
   logic [31:0] b_addr = '0, b_wdata = '0, b_rsp_rdata;

   typedef struct {
      int          acc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int b_last_acc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   dmem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_write(a_write), .req_funct3(a_funct3),
      .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_valid), .req_write(b_write), .req_funct3(b_funct3),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Monitor for instance a: pop and compare on every response cycle
   always @(negedge clk) begin
      exp_t e;
      if (a_rsp_valid === 1'b1) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
         end else begin
            e = qa.pop_front();
            chk("a_latency", 32'(cyc - e.acc), 32'(LAT_A));
            chk("a_rdata", a_rsp_rdata, e.rdata);
            chk("a_err", 32'(a_rsp_err), 32'(e.err));
         end
      end else if (cyc > 0) begin
         chk("a_idle_outputs", a_rsp_rdata | 32'(a_rsp_err), 32'd0);
      end
   end

   // Monitor for instance b
   always @(negedge clk) begin
      exp_t e;
      if (b_rsp_valid === 1'b1) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
         end else begin
            e = qb.pop_front();
            chk("b_latency", 32'(cyc - e.acc), 32'(LAT_B));
            chk("b_rdata", b_rsp_rdata, e.rdata);
            chk("b_err", 32'(b_rsp_err), 32'(e.err));
         end
      end
   end

   // One complete request on instance a, waits for its response
   task automatic req_a(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      bit   ok;
      a_valid = 1'b1; a_write = w; a_funct3 = f3; a_addr = addr; a_wdata = wdata;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) chk("a_accept_timeout", 32'(a_ready), 32'd1);
      else begin
         e.acc = cyc + 1; e.rdata = exp_rd; e.err = exp_err;
         qa.push_back(e);
      end
      @(posedge clk); #1;
      a_valid = 1'b0; a_wdata = 32'h5555_5555; a_addr = 32'h0000_0FFC;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (qa.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("a_rsp_timeout", 32'(qa.size()), 32'd0);
      @(posedge clk); #1;
      chk("a_ready_after_rsp", 32'(a_ready), 32'd1);
   endtask

   // Request on instance b with req_valid left high afterwards
   task automatic req_b_held(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd, input bit first);
      exp_t e;
      bit   ok;
      b_valid = 1'b1; b_write = w; b_funct3 = f3; b_addr = addr; b_wdata = wdata;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b_ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) chk("b_accept_timeout", 32'(b_ready), 32'd1);
      else begin
         e.acc = cyc + 1; e.rdata = exp_rd; e.err = 1'b0;
         if (!first) chk("b_accept_spacing", 32'(e.acc - b_last_acc), 32'd2);
         b_last_acc = e.acc;
         qb.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'(a_ready), 32'd1);
      chk("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("reset_rdata", a_rsp_rdata, 32'd0);
      chk("reset_err", 32'(a_rsp_err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Word store and load-back
      req_a(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      req_a(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Byte store into top lane, signed/unsigned byte loads
      req_a(1'b1, F3_B, 32'h13, 32'h1234_5680, 32'h0, 1'b0);
      req_a(1'b0, F3_B, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
      req_a(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
      req_a(1'b0, F3_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0);

      // Half store and half loads, including a misaligned one
      req_a(1'b1, F3_H, 32'h12, 32'hABCD_1234, 32'h0, 1'b0);
      req_a(1'b0, F3_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0);
      req_a(1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1);
      req_a(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
      req_a(1'b0, F3_H, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0);

      // Misaligned, out-of-range and illegal-funct3 requests leave memory alone
      req_a(1'b1, F3_W, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0);
      req_a(1'b1, F3_W, 32'h00, 32'h0BAD_F00D, 32'h0, 1'b0);
      req_a(1'b1, F3_W, 32'h16, 32'h1111_1111, 32'h0, 1'b1);
      req_a(1'b1, F3_W, 32'h1000, 32'h2222_2222, 32'h0, 1'b1);
      req_a(1'b0, F3_W, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0);
      req_a(1'b0, F3_W, 32'h00, 32'h0, 32'h0BAD_F00D, 1'b0);
      req_a(1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1);
      req_a(1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1);
      req_a(1'b1, 3'b011, 32'h14, 32'h3333_3333, 32'h0, 1'b1);
      req_a(1'b1, F3_BU, 32'h14, 32'h4444_4444, 32'h0, 1'b1);
      req_a(1'b0, F3_W, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
      req_a(1'b0, F3_W, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0);

      // Reset during WAIT drops the in-flight store and its response
      req_a(1'b1, F3_W, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
      a_valid = 1'b1; a_write = 1'b1; a_funct3 = F3_W; a_addr = 32'h20; a_wdata = 32'hFFFF_FFFF;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) chk("a_rst_accept_timeout", 32'(a_ready), 32'd1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(negedge clk);
      chk("a_busy_in_wait", 32'(a_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("a_ready_in_reset", 32'(a_ready), 32'd1);
      chk("a_rsp_in_reset", 32'(a_rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("a_ready_post_reset", 32'(a_ready), 32'd1);
      @(posedge clk); #1;
      req_a(1'b0, F3_W, 32'h20, 32'h0, 32'h1122_3344, 1'b0);

      // Zero-latency instance with req_valid held across four requests
      req_b_held(1'b1, F3_W, 32'h40, 32'hA5A5_0001, 32'h0, 1'b1);
      req_b_held(1'b0, F3_W, 32'h40, 32'h0, 32'hA5A5_0001, 1'b0);
      req_b_held(1'b1, F3_W, 32'h44, 32'h5A5A_0002, 32'h0, 1'b0);
      req_b_held(1'b0, F3_W, 32'h44, 32'h0, 32'h5A5A_0002, 1'b0);
      b_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (qb.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("b_rsp_timeout", 32'(qb.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
